// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM configuration: command encodings, bus widths and arbiter state encoding.
// Used by the arbiter and by the init, write and read engines.
package sdram_arbiter_pkg;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000,
        CMD_AREF  = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WRITE = 4'b0100,
        CMD_READ  = 4'b0101,
        CMD_NOP   = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARB   = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_mux.sv
// Combinational source select for the shared SDRAM command/address bus,
// keyed on the arbiter's registered state.
module sdram_arbiter_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int BANK_W_P = BANK_W
) (
    input  arb_state_e          state,
    input  logic [3:0]          init_cmd,
    input  logic [BANK_W_P-1:0] init_bank,
    input  logic [ADDR_W_P-1:0] init_addr,
    input  logic [3:0]          aref_cmd,
    input  logic [BANK_W_P-1:0] aref_bank,
    input  logic [ADDR_W_P-1:0] aref_addr,
    input  logic [3:0]          wr_cmd,
    input  logic [BANK_W_P-1:0] wr_bank,
    input  logic [ADDR_W_P-1:0] wr_addr,
    input  logic                wr_dq_en,
    input  logic [3:0]          rd_cmd,
    input  logic [BANK_W_P-1:0] rd_bank,
    input  logic [ADDR_W_P-1:0] rd_addr,
    output logic [3:0]          sdram_cmd,
    output logic [BANK_W_P-1:0] sdram_bank,
    output logic [ADDR_W_P-1:0] sdram_addr,
    output logic                sdram_dq_oe
);

    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_bank  = '0;
        sdram_addr  = '0;
        sdram_dq_oe = 1'b0;
        unique case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_bank = aref_bank;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_bank  = wr_bank;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_en;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus sequencer: waits for init, then grants the bus exclusively to
// refresh (highest priority), write or read, alternating write/read under contention.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int BANK_W_P = BANK_W,
    parameter int DQ_W_P   = DQ_W
) (
    input  logic                arb_clk,
    input  logic                arb_rst_n,
    input  logic                init_end,
    input  logic [3:0]          init_cmd,
    input  logic [BANK_W_P-1:0] init_bank,
    input  logic [ADDR_W_P-1:0] init_addr,
    input  logic                aref_req,
    input  logic                aref_end,
    input  logic [3:0]          aref_cmd,
    input  logic [BANK_W_P-1:0] aref_bank,
    input  logic [ADDR_W_P-1:0] aref_addr,
    input  logic                wr_req,
    input  logic                wr_end,
    input  logic                wr_sdram_en,
    input  logic [3:0]          wr_sdram_cmd,
    input  logic [BANK_W_P-1:0] wr_sdram_bank,
    input  logic [ADDR_W_P-1:0] wr_sdram_addr,
    input  logic [DQ_W_P-1:0]   wr_sdram_data,
    input  logic                rd_req,
    input  logic                rd_end,
    input  logic [3:0]          rd_sdram_cmd,
    input  logic [BANK_W_P-1:0] rd_sdram_bank,
    input  logic [ADDR_W_P-1:0] rd_sdram_addr,
    output logic                aref_en,
    output logic                wr_en,
    output logic                rd_en,
    output logic [3:0]          sdram_cmd,
    output logic [BANK_W_P-1:0] sdram_bank,
    output logic [ADDR_W_P-1:0] sdram_addr,
    output logic                sdram_dq_oe,
    output logic [DQ_W_P-1:0]   sdram_dq_out,
    output logic                arb_busy
);

    arb_state_e state_q, state_d;
    logic       last_wr_q, last_wr_d;
    logic       aref_en_q, aref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            ST_INIT: if (init_end) state_d = ST_ARB;
            ST_ARB: begin
                if (aref_req)                         state_d = ST_AREF;
                else if (wr_req && (!rd_req || !last_wr_q)) state_d = ST_WRITE;
                else if (rd_req)                      state_d = ST_READ;
            end
            ST_AREF: if (aref_end) state_d = ST_ARB;
            ST_WRITE: if (wr_end) begin
                state_d   = ST_ARB;
                last_wr_d = 1'b1;
            end
            ST_READ: if (rd_end) begin
                state_d   = ST_ARB;
                last_wr_d = 1'b0;
            end
            default: state_d = ST_INIT;
        endcase
        // Losing init_end anywhere past INIT forces a full re-initialisation.
        if (state_q != ST_INIT && !init_end) state_d = ST_INIT;

        // Grants are registered copies of the next state, so they change on the same edge.
        aref_en_d = (state_d == ST_AREF);
        wr_en_d   = (state_d == ST_WRITE);
        rd_en_d   = (state_d == ST_READ);
        busy_d    = aref_en_d | wr_en_d | rd_en_d;
    end

    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
        end
    end

    assign aref_en      = aref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign arb_busy     = busy_q;
    assign sdram_dq_out = wr_sdram_data;

    sdram_arbiter_mux #(
        .ADDR_W_P (ADDR_W_P),
        .BANK_W_P (BANK_W_P)
    ) u_mux (
        .state       (state_q),
        .init_cmd    (init_cmd),
        .init_bank   (init_bank),
        .init_addr   (init_addr),
        .aref_cmd    (aref_cmd),
        .aref_bank   (aref_bank),
        .aref_addr   (aref_addr),
        .wr_cmd      (wr_sdram_cmd),
        .wr_bank     (wr_sdram_bank),
        .wr_addr     (wr_sdram_addr),
        .wr_dq_en    (wr_sdram_en),
        .rd_cmd      (rd_sdram_cmd),
        .rd_bank     (rd_sdram_bank),
        .rd_addr     (rd_sdram_addr),
        .sdram_cmd   (sdram_cmd),
        .sdram_bank  (sdram_bank),
        .sdram_addr  (sdram_addr),
        .sdram_dq_oe (sdram_dq_oe)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init hand-off, grants, priority, alternation, reset and re-init.
module tb_sdram_arbiter;

    logic        arb_clk = 1'b0;
    logic        arb_rst_n, init_end;
    logic [3:0]  init_cmd, aref_cmd, wr_sdram_cmd, rd_sdram_cmd;
    logic [1:0]  init_bank, aref_bank, wr_sdram_bank, rd_sdram_bank;
    logic [12:0] init_addr, aref_addr, wr_sdram_addr, rd_sdram_addr;
    logic        aref_req, aref_end, wr_req, wr_end, wr_sdram_en, rd_req, rd_end;
    logic [15:0] wr_sdram_data;
    logic        aref_en, wr_en, rd_en, sdram_dq_oe, arb_busy;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    int checks = 0;
    int errors = 0;
    int busy_run = 0;

    localparam logic [18:0] BUS_NOP  = {4'b0111, 2'd0, 13'h0000};
    localparam logic [18:0] BUS_INIT = {4'b0010, 2'd1, 13'h00AA};
    localparam logic [18:0] BUS_AREF = {4'b0001, 2'd2, 13'h0400};
    localparam logic [18:0] BUS_WR   = {4'b0100, 2'd3, 13'h0123};
    localparam logic [18:0] BUS_RD   = {4'b0101, 2'd1, 13'h0456};

    sdram_arbiter dut (
        .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_en(wr_sdram_en),
        .wr_sdram_cmd(wr_sdram_cmd), .wr_sdram_bank(wr_sdram_bank),
        .wr_sdram_addr(wr_sdram_addr), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end),
        .rd_sdram_cmd(rd_sdram_cmd), .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out), .arb_busy(arb_busy)
    );

    always #5 arb_clk = ~arb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] en, input logic busy, input logic [18:0] bus);
        chk({tag, " en"},   {29'd0, aref_en, wr_en, rd_en}, {29'd0, en});
        chk({tag, " busy"}, {31'd0, arb_busy}, {31'd0, busy});
        chk({tag, " bus"},  {13'd0, sdram_cmd, sdram_bank, sdram_addr}, {13'd0, bus});
    endtask

    // A grant must never be held without its end pulse arriving.
    always @(negedge arb_clk) begin
        busy_run = arb_busy ? busy_run + 1 : 0;
        if (busy_run == 64) chk("grant watchdog", 32'd1, 32'd0);
    end

    initial begin
        {init_cmd, init_bank, init_addr} = BUS_INIT;
        {aref_cmd, aref_bank, aref_addr} = BUS_AREF;
        {wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr} = BUS_WR;
        {rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr} = BUS_RD;
        arb_rst_n = 1'b0; init_end = 1'b0;
        aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
        wr_sdram_en = 0; wr_sdram_data = 16'h0;

        repeat (10) step();
        chk_state("reset", 3'b000, 1'b0, BUS_INIT);
        arb_rst_n = 1'b1;
        for (int c = 10; c < 50; c++) begin
            step();
            chk_state("init hold", 3'b000, 1'b0, BUS_INIT);
        end
        init_end = 1'b1;
        step();
        chk_state("init done", 3'b000, 1'b0, BUS_NOP);
        wr_sdram_en = 1'b1;
        #1 chk("oe in arb", {31'd0, sdram_dq_oe}, 32'd0);
        wr_sdram_en = 1'b0;

        // Single write with a data ramp
        wr_req = 1'b1;
        step();
        chk_state("wr grant", 3'b010, 1'b1, BUS_WR);
        wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_sdram_en = 1'b1;
            wr_sdram_data = 16'(i);
            #1;
            chk("ramp dq", {16'd0, sdram_dq_out}, i);
            chk("ramp oe", {31'd0, sdram_dq_oe}, 32'd1);
            step();
        end
        wr_sdram_en = 1'b0;
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_state("wr end", 3'b000, 1'b0, BUS_NOP);
        chk("oe after wr", {31'd0, sdram_dq_oe}, 32'd0);
        step();
        chk_state("idle arb", 3'b000, 1'b0, BUS_NOP);

        // Refresh beats a simultaneous write; stray wr_end ignored
        aref_req = 1'b1; wr_req = 1'b1;
        step();
        chk_state("aref first", 3'b100, 1'b1, BUS_AREF);
        aref_req = 1'b0; wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_state("stray wr_end", 3'b100, 1'b1, BUS_AREF);
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk_state("aref end", 3'b000, 1'b0, BUS_NOP);
        step();
        chk_state("wr after aref", 3'b010, 1'b1, BUS_WR);
        wr_req = 1'b0; wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_state("wr2 end", 3'b000, 1'b0, BUS_NOP);

        // Lone read leaves last_wr clear
        rd_req = 1'b1;
        step();
        chk_state("rd grant", 3'b001, 1'b1, BUS_RD);
        rd_req = 1'b0; rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_state("rd end", 3'b000, 1'b0, BUS_NOP);

        // Both pending: WRITE, READ, WRITE, READ
        wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            if (g % 2 == 0) chk_state("alt wr", 3'b010, 1'b1, BUS_WR);
            else            chk_state("alt rd", 3'b001, 1'b1, BUS_RD);
            step();
            if (g % 2 == 0) begin chk_state("alt wr hold", 3'b010, 1'b1, BUS_WR); wr_end = 1'b1; end
            else            begin chk_state("alt rd hold", 3'b001, 1'b1, BUS_RD); rd_end = 1'b1; end
            step();
            wr_end = 1'b0; rd_end = 1'b0;
            chk_state("alt gap", 3'b000, 1'b0, BUS_NOP);
        end

        // Refresh raised mid-write with read pending: WRITE, AREF, READ
        step();
        chk_state("mid wr", 3'b010, 1'b1, BUS_WR);
        wr_req = 1'b0;
        aref_req = 1'b1;
        step();
        chk_state("no preempt", 3'b010, 1'b1, BUS_WR);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_state("mid wr end", 3'b000, 1'b0, BUS_NOP);
        step();
        chk_state("aref over rd", 3'b100, 1'b1, BUS_AREF);
        aref_req = 1'b0; aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk_state("aref2 end", 3'b000, 1'b0, BUS_NOP);
        step();
        chk_state("rd after aref", 3'b001, 1'b1, BUS_RD);

        // Reset during READ, then a stray rd_end
        arb_rst_n = 1'b0;
        step();
        chk_state("rst in rd", 3'b000, 1'b0, BUS_INIT);
        arb_rst_n = 1'b1; rd_req = 1'b0; rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_state("stray rd_end", 3'b000, 1'b0, BUS_NOP);
        step();
        chk_state("post rst idle", 3'b000, 1'b0, BUS_NOP);

        // init_end dropping during a grant forces INIT
        wr_req = 1'b1;
        step();
        chk_state("wr pre reinit", 3'b010, 1'b1, BUS_WR);
        wr_req = 1'b0; init_end = 1'b0;
        step();
        chk_state("reinit", 3'b000, 1'b0, BUS_INIT);
        step();
        chk_state("reinit hold", 3'b000, 1'b0, BUS_INIT);
        init_end = 1'b1;
        step();
        chk_state("reinit done", 3'b000, 1'b0, BUS_NOP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
